majority_gate_n_bit_top: RTL and testbench

- Registered N-input majority voter.
- Each clock it samples the N-bit vector X, counts the set bits, and drives Y high when strictly more than half of the bits are 1.
- It also exports the population count and a tie flag for even N.
- Used as a voting/redundancy primitive, for example TMR-style vote or bus-level consensus, inside larger datapaths.

---
 rtl/majority_pkg.sv | 11 +
 rtl/popcount_n.sv | 32 +++
 rtl/majority_gate_n_bit_top.sv | 56 +++++
 tb/tb_majority_gate_n_bit_top.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/majority_pkg.sv
// Shared definitions for the N-input majority voter: count-width helper and tie policy.
package majority_pkg;

  // Width needed to hold the value n itself, so a full-ones vote never overflows.
  function automatic int clog2_plus1(input int n);
    return $clog2(n + 1);
  endfunction

  localparam logic MAJ_TIE_RESOLVE = 1'b0;

endpackage

// File: rtl/popcount_n.sv
// Combinational population count of an N-bit vector, built as a balanced adder tree.
module popcount_n
  import majority_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]                 x,
  output logic [clog2_plus1(N)-1:0]    count
);

  localparam int CW = clog2_plus1(N);
  localparam int P  = (N <= 1) ? 1 : (1 << $clog2(N));

  // Heap layout: leaves at P..2P-1, node i sums children 2i and 2i+1, root at 1.
  logic [P-1:0]  x_pad;
  logic [CW-1:0] node [1:2*P-1];

  assign x_pad = P'(x);

  // NOTE: a single always_comb writes every node before it is read, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      node[P + i] = CW'(x_pad[i]);
    end
    for (int i = P - 1; i >= 1; i--) begin
      node[i] = node[2 * i] + node[2 * i + 1];
    end
  end

  assign count = node[1];

endmodule

// File: rtl/majority_gate_n_bit_top.sv
// Registered N-input majority voter exporting the ones count and an even-N tie flag.
module majority_gate_n_bit_top
  import majority_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = clog2_plus1(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  X,
  output logic          Y,
  output logic [CW-1:0] ones_count,
  output logic          tie
);

  localparam int HALF = N / 2;
  localparam bit EVEN = (N % 2) == 0;

  logic [1:0]    rst_sync;
  logic          rst_core_n;
  logic [CW-1:0] cnt;
  logic          maj;
  logic          tie_d;
  logic          y_d;

  // Assertion passes straight through; release is delayed by two clean edges.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_core_n = rst_sync[1];

  popcount_n #(.N(N)) u_popcount (
    .x     (X),
    .count (cnt)
  );

  assign maj   = int'(cnt) > HALF;
  assign tie_d = EVEN && (int'(cnt) == HALF);
  assign y_d   = tie_d ? MAJ_TIE_RESOLVE : maj;

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      Y          <= 1'b0;
      ones_count <= '0;
      tie        <= 1'b0;
    end else begin
      Y          <= y_d;
      ones_count <= cnt;
      tie        <= tie_d;
    end
  end

endmodule

// File: tb/tb_majority_gate_n_bit_top.sv
// Self-checking bench: N=8, 7, 2 and 1 voters driven side by side against a popcount model.
module tb_majority_gate_n_bit_top;

  logic       clk;
  logic       rst_n;
  logic [7:0] x8;
  logic [6:0] x7;
  logic [1:0] x2;
  logic [0:0] x1;
  logic       y8, y7, y2, y1;
  logic [3:0] c8;
  logic [2:0] c7;
  logic [1:0] c2;
  logic [0:0] c1;
  logic       t8, t7, t2, t1;

  int errors = 0;
  int checks = 0;

  majority_gate_n_bit_top #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .X(x8), .Y(y8), .ones_count(c8), .tie(t8));
  majority_gate_n_bit_top #(.N(7)) dut7 (.clk(clk), .rst_n(rst_n), .X(x7), .Y(y7), .ones_count(c7), .tie(t7));
  majority_gate_n_bit_top #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .X(x2), .Y(y2), .ones_count(c2), .tie(t2));
  majority_gate_n_bit_top #(.N(1)) dut1 (.clk(clk), .rst_n(rst_n), .X(x1), .Y(y1), .ones_count(c1), .tie(t1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic       y;
    logic [3:0] cnt;
    logic       tie;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: count ones, majority when twice the count exceeds N, tie when it equals N.
  task automatic check_vote(input string tag, input int n, input logic [63:0] v,
                            input logic y, input logic [63:0] cnt, input logic t);
    int ones;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(v[i]);
    check({tag, ".Y"},   64'(y),  64'(2 * ones > n));
    check({tag, ".cnt"}, cnt,     64'(ones));
    check({tag, ".tie"}, 64'(t),  64'(2 * ones == n));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic [7:0] v);
    x8 = v;
    x7 = v[6:0];
    x2 = v[1:0];
    x1 = v[0:0];
  endtask

  task automatic check_all(input logic [7:0] v, input string tag);
    check_vote({tag, ".n8"}, 8, 64'(v),      y8, 64'(c8), t8);
    check_vote({tag, ".n7"}, 7, 64'(v[6:0]), y7, 64'(c7), t7);
    check_vote({tag, ".n2"}, 2, 64'(v[1:0]), y2, 64'(c2), t2);
    check_vote({tag, ".n1"}, 1, 64'(v[0]),   y1, 64'(c1), t1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".Y"},   64'(y8), 64'd0);
    check({tag, ".cnt"}, 64'(c8), 64'd0);
    check({tag, ".tie"}, 64'(t8), 64'd0);
  endtask

  // Release reset and confirm two synchroniser edges pass before X is first captured.
  task automatic release_and_check(input string tag);
    rst_n = 1'b1;
    tick();
    check_zero({tag, ".sync1"});
    tick();
    check_zero({tag, ".sync2"});
    tick();
    check_all(x8, {tag, ".first"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t table8[8];
    logic [7:0] prev;

    table8[0] = '{x: 8'h0F, y: 1'b0, cnt: 4'd4, tie: 1'b1};
    table8[1] = '{x: 8'h1F, y: 1'b1, cnt: 4'd5, tie: 1'b0};
    table8[2] = '{x: 8'hFF, y: 1'b1, cnt: 4'd8, tie: 1'b0};
    table8[3] = '{x: 8'h00, y: 1'b0, cnt: 4'd0, tie: 1'b0};
    table8[4] = '{x: 8'h80, y: 1'b0, cnt: 4'd1, tie: 1'b0};
    table8[5] = '{x: 8'hFE, y: 1'b1, cnt: 4'd7, tie: 1'b0};
    table8[6] = '{x: 8'hF0, y: 1'b0, cnt: 4'd4, tie: 1'b1};
    table8[7] = '{x: 8'hF8, y: 1'b1, cnt: 4'd5, tie: 1'b0};

    // Reset held with all-ones inputs: outputs must stay cleared through clock edges.
    rst_n = 1'b0;
    drive_all(8'hFF);
    tick();
    tick();
    check_zero("reset_hold");
    check("reset_hold.n7.Y", 64'(y7), 64'd0);
    check("reset_hold.n1.Y", 64'(y1), 64'd0);
    release_and_check("por");

    for (int i = 0; i < 8; i++) begin
      drive_all(table8[i].x);
      tick();
      check($sformatf("table[%0d].Y", i),   64'(y8), 64'(table8[i].y));
      check($sformatf("table[%0d].cnt", i), 64'(c8), 64'(table8[i].cnt));
      check($sformatf("table[%0d].tie", i), 64'(t8), 64'(table8[i].tie));
    end

    // Hand-picked odd and narrow cases.
    drive_all(8'h07);
    tick();
    check("n7_07.Y",   64'(y7), 64'd0);
    check("n7_07.cnt", 64'(c7), 64'd3);
    drive_all(8'h0F);
    tick();
    check("n7_0F.Y",   64'(y7), 64'd1);
    check("n7_0F.cnt", 64'(c7), 64'd4);
    drive_all(8'h01);
    tick();
    check("n2_01.Y",   64'(y2), 64'd0);
    check("n2_01.tie", 64'(t2), 64'd1);
    check("n1_1.Y",    64'(y1), 64'd1);
    drive_all(8'h03);
    tick();
    check("n2_11.Y",   64'(y2), 64'd1);
    check("n2_11.tie", 64'(t2), 64'd0);

    // Exhaustive back-to-back sweep, one vector per clock.
    for (int v = 0; v < 256; v++) begin
      drive_all(v[7:0]);
      tick();
      check_all(v[7:0], $sformatf("sweep[%0d]", v));
    end

    // Alternation: each output must follow its own vector with no dropped sample.
    for (int i = 0; i < 8; i++) begin
      drive_all((i % 2 == 0) ? 8'hF0 : 8'hF8);
      tick();
      check($sformatf("alt[%0d].Y", i),   64'(y8), 64'(i % 2));
      check($sformatf("alt[%0d].tie", i), 64'(t8), 64'((i + 1) % 2));
    end

    // Randomised vectors, also changing X mid-cycle to show the outputs hold.
    for (int i = 0; i < 200; i++) begin
      prev = 8'($urandom);
      drive_all(prev);
      tick();
      check_all(prev, $sformatf("rand[%0d]", i));
      #2;
      drive_all(~prev);
      #1;
      check_all(prev, $sformatf("rand_hold[%0d]", i));
    end

    // Mid-stream reset: outputs clear without any clock edge, in-flight sample dropped.
    drive_all(8'hFF);
    tick();
    check_all(8'hFF, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    check("mid_rst.n7.Y", 64'(y7), 64'd0);
    check("mid_rst.n2.cnt", 64'(c2), 64'd0);
    tick();
    check_zero("mid_rst_edge");
    drive_all(8'h1F);
    release_and_check("rerelease");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
